cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Control unit that drives the RISC datapath's control inputs. It fetches 16-bit instructions from memory, holds them in an instruction register and decodes them. A Moore FSM then sequences readnum/writenum/vsel/load strobes/ALUop/shift/sel signals cycle by cycle. It also owns the 9-bit PC and data address register, supplies sximm8, sximm5 and PC to the datapath, and issues memory read/write commands.

Parameters:
PC_W, 9, program counter and memory address width
RESET_PC, 9'd0, PC value loaded in the RST state

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in  input  16  memory read data (instruction or mdata), valid the cycle after mem_addr/READ are presented, held while they are held
datapath_out  input  16  datapath C register, used for the load-address value
readnum  output  3  register file read select
writenum  output  3  register file write select
write  output  1  register file write enable
vsel  output  2  write-back source: 00 C, 01 PC, 10 mdata, 11 sximm8
loada, loadb, loadc, loads  output  1 each  datapath register enables
asel  output  1  1 selects A=0
bsel  output  1  1 selects B=sximm5
shift  output  2  shifter control
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
sximm8  output  16  IR[7:0] sign-extended
sximm5  output  16  IR[4:0] sign-extended
PC  output  9  current program counter
mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE
mem_addr  output  9  memory address
halted  output  1  high in HALT state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset effect: reset high takes state to RST, PC to RESET_PC, IR to 0 and data_addr to 0 on the next edge. While reset is high, write, load*, and mem_cmd are forced to 0/NONE in the same cycle. Reset is honoured from any state, including mid-instruction.
- Instruction fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Output timing: all outputs decode combinationally from state and IR (Moore). Outputs not listed for a state are 0.
- Fetch sequence:
  - RST -> IF1.
  - IF1: mem_addr=PC, mem_cmd=READ -> IF2.
  - IF2: same address and command; IR<=in -> UPD_PC.
  - UPD_PC: PC<=PC+1, wrapping 511->0 -> DECODE.
  - DECODE: no strobes; branches on {opcode,op}.
- MOV Rn,#imm8 (110,10): WR_IMM, with writenum=Rn, vsel=11, write=1 -> IF1.
- MOV Rd,Rm,sh (110,00): GET_B -> ALU -> WR_REG.
  - ALU state: asel=1, bsel=0, ALUop=00, shift=sh, loadc=1.
- ADD/AND (101,00 / 101,10): GET_A -> GET_B -> ALU -> WR_REG.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU state: asel=0, bsel=0, ALUop=op, shift=sh, loadc=1.
  - WR_REG: writenum=Rd, vsel=00, write=1 -> IF1.
- MVN (101,11): GET_B -> ALU (ALUop=11) -> WR_REG.
- CMP (101,01): GET_A -> GET_B -> ALU with ALUop=01, loads=1, loadc=0 -> IF1. write is never asserted.
- LDR Rd,[Rn,#imm5] (011,00):
  - GET_A.
  - ADDR: asel=0, bsel=1, ALUop=00, shift=00, loadc=1.
  - LD_ADDR: data_addr<=datapath_out[8:0].
  - MEM_RD: mem_addr=data_addr, mem_cmd=READ.
  - MEM_WB: mem_addr=data_addr, mem_cmd=READ, vsel=10, writenum=Rd, write=1 -> IF1.
- STR Rd,[Rn,#imm5] (100,00):
  - GET_A -> ADDR -> LD_ADDR.
  - GET_D: readnum=Rd, loadb=1.
  - PASS: asel=1, bsel=0, shift=00, ALUop=00, loadc=1.
  - MEM_WR: mem_addr=data_addr, mem_cmd=WRITE -> IF1. Write data is datapath_out, wired externally.
- HALT (111) and any undefined {opcode,op}: enter HALT.
  - halted=1, mem_cmd=NONE, PC frozen.
  - Stays in HALT until reset.
- mem_addr in non-memory states is PC; mem_cmd there is NONE.
- Width rules: sximm8 and sximm5 are pure sign extension. PC arithmetic is modulo 2^9.

Decomposition:
- Package cpu_pkg holds:
  - state enum;
  - opcode/op localparams;
  - mem_cmd encodings (MNONE, MREAD, MWRITE);
  - vsel encodings;
  - ALUop encodings.
- Sub-module instr_decoder: combinational. Takes IR and outputs opcode, op, Rn, Rd, Rm, sh, sximm8, sximm5.
- FSM, PC, IR and data_addr live in cpu_controller.

Test Plan:
- Reset, then memory[0]=16'hD007 (MOV R0,#7) -> IF1 shows mem_addr=0 and mem_cmd=READ. WR_IMM occurs 5 cycles after RST with writenum=0, vsel=11, sximm8=16'h0007, write=1, and PC=1.
- MOV R1,#-2 (16'hD1FE) -> sximm8=16'hFFFE, writenum=1, write=1.
- ADD R2,R0,R1,LSL#1 (16'hA049):
  - GET_A: readnum=0, loada=1.
  - GET_B: readnum=1, loadb=1.
  - ALU: shift=01, ALUop=00, loadc=1.
  - WR_REG: writenum=2, vsel=00, write=1.
- CMP R0,R1 (16'hA801) -> ALU state has ALUop=01, loads=1, loadc=0. write stays 0 for the whole instruction.
- LDR R3,[R0,#2] (16'h6062) with datapath_out=9 at LD_ADDR:
  - ADDR: bsel=1, sximm5=16'h0002.
  - MEM_RD: mem_addr=9, mem_cmd=READ.
  - MEM_WB: vsel=10, writenum=3, write=1.
  - STR variant (16'h8062): MEM_WR has mem_addr=9, mem_cmd=WRITE.
- HALT and reset cases:
  - 16'hE000 -> halted=1, mem_cmd=NONE and PC frozen for 20 cycles.
  - Reset asserted in GET_B -> strobes are 0 that cycle, and state=RST, PC=0 next cycle.
  - PC preset to 511 -> UPD_PC wraps PC to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the RISC control unit: FSM states, opcode/op
// values, memory command, write-back select and ALU operation codes.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD_PC,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_GET_D,
        S_PASS,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MEM  = 2'b00;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_MDATA = 2'b10;
    localparam logic [1:0] VSEL_IMM   = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/cpu_if.sv
// Memory bus between the control unit (master) and instruction/data memory (slave).
interface cpu_if #(
    parameter int PC_W = 9
);
    logic [15:0]     in;
    logic [1:0]      mem_cmd;
    logic [PC_W-1:0] mem_addr;

    modport master (input in, output mem_cmd, output mem_addr);
    modport slave  (output in, input mem_cmd, input mem_addr);
endinterface

// File: rtl/cpu_instr_decoder.sv
// Combinational field extraction and immediate sign extension from the IR.
module instr_decoder (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// Moore control unit: fetches into IR, decodes, and sequences datapath strobes
// and memory commands; owns PC and the load/store data address register.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    cpu_if.master           bus,
    input  logic [15:0]     datapath_out,
    output logic [2:0]      readnum,
    output logic [2:0]      writenum,
    output logic            write,
    output logic [1:0]      vsel,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5,
    output logic [PC_W-1:0] PC,
    output logic            halted
);
    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     ir_reg;
    logic [PC_W-1:0] data_addr_reg;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_cmp;
    logic [1:0]      mem_cmd_next;
    logic [PC_W-1:0] mem_addr_next;

    // Only the low address bits of the datapath result form a memory address.
    logic unused_dp_bits;
    assign unused_dp_bits = ^datapath_out[15:PC_W];

    instr_decoder u_dec (
        .ir     (ir_reg),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    assign is_cmp       = (opcode == OPC_ALU) && (op == OP_CMP);
    assign PC           = pc_reg;
    assign bus.mem_cmd  = mem_cmd_next;
    assign bus.mem_addr = mem_addr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_RST;
            pc_reg        <= RESET_PC;
            ir_reg        <= '0;
            data_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IF2)
                ir_reg <= bus.in;
            if (state_reg == S_UPD_PC)
                pc_reg <= pc_reg + 1'b1;
            if (state_reg == S_LD_ADDR)
                data_addr_reg <= datapath_out[PC_W-1:0];
        end
    end

    always_comb begin
        state_next    = state_reg;
        readnum       = 3'd0;
        writenum      = 3'd0;
        write         = 1'b0;
        vsel          = VSEL_C;
        loada         = 1'b0;
        loadb         = 1'b0;
        loadc         = 1'b0;
        loads         = 1'b0;
        asel          = 1'b0;
        bsel          = 1'b0;
        shift         = 2'b00;
        ALUop         = ALU_ADD;
        mem_cmd_next  = MNONE;
        mem_addr_next = pc_reg;
        halted        = 1'b0;

        case (state_reg)
            S_RST:    state_next = S_IF1;
            S_IF1: begin
                mem_cmd_next = MREAD;
                state_next   = S_IF2;
            end
            S_IF2: begin
                mem_cmd_next = MREAD;
                state_next   = S_UPD_PC;
            end
            S_UPD_PC: state_next = S_DECODE;
            S_DECODE: begin
                case ({opcode, op})
                    {OPC_MOV, OP_MOVI}: state_next = S_WR_IMM;
                    {OPC_MOV, OP_MOVR}: state_next = S_GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_AND},
                    {OPC_ALU, OP_CMP}:  state_next = S_GET_A;
                    {OPC_ALU, OP_MVN}:  state_next = S_GET_B;
                    {OPC_LDR, OP_MEM},
                    {OPC_STR, OP_MEM}:  state_next = S_GET_A;
                    default:            state_next = S_HALT;
                endcase
            end
            S_WR_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_ALU;
            end
            S_ALU: begin
                // MOV Rd,Rm passes B through by adding it to a zeroed A.
                asel       = (opcode == OPC_MOV);
                ALUop      = (opcode == OPC_MOV) ? ALU_ADD : op;
                shift      = sh;
                loads      = is_cmp;
                loadc      = !is_cmp;
                state_next = is_cmp ? S_IF1 : S_WR_REG;
            end
            S_WR_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LD_ADDR;
            end
            S_LD_ADDR: state_next = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
            S_MEM_RD: begin
                mem_addr_next = data_addr_reg;
                mem_cmd_next  = MREAD;
                state_next    = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_addr_next = data_addr_reg;
                mem_cmd_next  = MREAD;
                vsel          = VSEL_MDATA;
                writenum      = rd;
                write         = 1'b1;
                state_next    = S_IF1;
            end
            S_GET_D: begin
                readnum    = rd;
                loadb      = 1'b1;
                state_next = S_PASS;
            end
            S_PASS: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_addr_next = data_addr_reg;
                mem_cmd_next  = MWRITE;
                state_next    = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_RST;
        endcase

        // Side-effecting strobes are suppressed in the very cycle reset rises.
        if (reset) begin
            write        = 1'b0;
            loada        = 1'b0;
            loadb        = 1'b0;
            loadc        = 1'b0;
            loads        = 1'b0;
            mem_cmd_next = MNONE;
        end
    end
endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: runs a small program through the controller and compares
// per-cycle Moore outputs against a hand-computed table, plus reset/wrap cases.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] datapath_out = 16'd9;
    always #5 clk = ~clk;

    cpu_if #(.PC_W(9)) bus ();
    cpu_if #(.PC_W(9)) bus2 ();

    logic [2:0]  readnum, writenum, readnum2, writenum2;
    logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
    logic        write2, loada2, loadb2, loadc2, loads2, asel2, bsel2, halted2;
    logic [1:0]  vsel, shift, ALUop, vsel2, shift2, ALUop2;
    logic [15:0] sximm8, sximm5, sximm8_2, sximm5_2;
    logic [8:0]  PC, PC2;

    cpu_controller #(.PC_W(9), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset(reset), .bus(bus.master), .datapath_out(datapath_out),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5), .PC(PC), .halted(halted)
    );

    cpu_controller #(.PC_W(9), .RESET_PC(9'd511)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2.master), .datapath_out(datapath_out),
        .readnum(readnum2), .writenum(writenum2), .write(write2), .vsel(vsel2),
        .loada(loada2), .loadb(loadb2), .loadc(loadc2), .loads(loads2),
        .asel(asel2), .bsel(bsel2), .shift(shift2), .ALUop(ALUop2),
        .sximm8(sximm8_2), .sximm5(sximm5_2), .PC(PC2), .halted(halted2)
    );

    // Synchronous-read program memory: data appears the cycle after the address.
    logic [15:0] prog [0:511];
    always @(posedge clk) bus.in <= prog[bus.mem_addr];

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  rn, wn;
        logic        wr;
        logic [1:0]  vs;
        logic [3:0]  ld;
        logic        asl, bsl;
        logic [1:0]  sh, op, mc;
        logic [8:0]  ma, pc;
        logic        hl;
        logic [15:0] s8, s5;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(int cyc, string name, logic [2:0] rn, logic [2:0] wn, logic wr,
                                logic [1:0] vs, logic [3:0] ld, logic asl, logic bsl,
                                logic [1:0] sh, logic [1:0] op, logic [1:0] mc, logic [8:0] ma,
                                logic [8:0] pc, logic hl, logic [15:0] s8, logic [15:0] s5);
        vec_t v;
        v.cyc = cyc; v.name = name; v.rn = rn; v.wn = wn; v.wr = wr; v.vs = vs; v.ld = ld;
        v.asl = asl; v.bsl = bsl; v.sh = sh; v.op = op; v.mc = mc; v.ma = ma; v.pc = pc;
        v.hl = hl; v.s8 = s8; v.s5 = s5;
        return v;
    endfunction

    function automatic logic [71:0] exp_vec(vec_t v);
        return {v.rn, v.wn, v.wr, v.vs, v.ld, v.asl, v.bsl, v.sh, v.op, v.mc, v.ma, v.pc, v.hl, v.s8, v.s5};
    endfunction

    function automatic logic [71:0] act_vec();
        return {readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                shift, ALUop, bus.mem_cmd, bus.mem_addr, PC, halted, sximm8, sximm5};
    endfunction

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    int vi = 0;
    int cmp_wr_bad = 0;
    int halt_bad = 0;

    initial begin
        for (int i = 0; i < 512; i++) prog[i] = 16'h0000;
        prog[0] = 16'hD007;  // MOV R0,#7
        prog[1] = 16'hD1FE;  // MOV R1,#-2
        prog[2] = 16'hA049;  // ADD R2,R0,R1,LSL#1
        prog[3] = 16'hA801;  // CMP R0,R1
        prog[4] = 16'h6062;  // LDR R3,[R0,#2]
        prog[5] = 16'h8062;  // STR R3,[R0,#2]
        prog[6] = 16'hE000;  // HALT
        bus2.in = 16'hE000;

        //                cyc name           rn wn wr vs ld       as bs sh op mc ma   pc   hl s8        s5
        vecs.push_back(mk(0,  "rst",         0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0,   0,   0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1,  "if1",         0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0,   0,   0, 16'h0000, 16'h0000));
        vecs.push_back(mk(2,  "if2",         0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 0,   0,   0, 16'h0000, 16'h0000));
        vecs.push_back(mk(3,  "upd_pc",      0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0,   0,   0, 16'h0007, 16'h0007));
        vecs.push_back(mk(5,  "wr_imm_r0",   0, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0, 1,   1,   0, 16'h0007, 16'h0007));
        vecs.push_back(mk(10, "wr_imm_r1",   0, 1, 1, 3, 4'b0000, 0, 0, 0, 0, 0, 2,   2,   0, 16'hFFFE, 16'hFFFE));
        vecs.push_back(mk(14, "add_decode",  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 3,   3,   0, 16'h0049, 16'h0009));
        vecs.push_back(mk(15, "add_get_a",   0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 3,   3,   0, 16'h0049, 16'h0009));
        vecs.push_back(mk(16, "add_get_b",   1, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 3,   3,   0, 16'h0049, 16'h0009));
        vecs.push_back(mk(17, "add_alu",     0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 3,   3,   0, 16'h0049, 16'h0009));
        vecs.push_back(mk(18, "add_wr_reg",  0, 2, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 3,   3,   0, 16'h0049, 16'h0009));
        vecs.push_back(mk(23, "cmp_get_a",   0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 4,   4,   0, 16'h0001, 16'h0001));
        vecs.push_back(mk(25, "cmp_alu",     0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, 4,   4,   0, 16'h0001, 16'h0001));
        vecs.push_back(mk(31, "ldr_addr",    0, 0, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 5,   5,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(32, "ldr_ld_addr", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 5,   5,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(33, "ldr_mem_rd",  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 9,   5,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(34, "ldr_mem_wb",  0, 3, 1, 2, 4'b0000, 0, 0, 0, 0, 1, 9,   5,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(42, "str_get_d",   3, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 6,   6,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(43, "str_pass",    0, 0, 0, 0, 4'b0010, 1, 0, 0, 0, 0, 6,   6,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(44, "str_mem_wr",  0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2, 9,   6,   0, 16'h0062, 16'h0002));
        vecs.push_back(mk(49, "halt",        0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 7,   7,   1, 16'h0000, 16'h0000));
        vecs.push_back(mk(69, "halt_late",   0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 7,   7,   1, 16'h0000, 16'h0000));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (vi < vecs.size() && vecs[vi].cyc == c) begin
                check(vecs[vi].name, act_vec(), exp_vec(vecs[vi]));
                vi++;
            end
            if (c >= 19 && c <= 25 && write) cmp_wr_bad++;
            if (c >= 50 && (!halted || PC != 9'd7 || bus.mem_cmd != 2'b00)) halt_bad++;
            if (c == 1) check("wrap_if1_addr", {bus2.mem_cmd, bus2.mem_addr}, {2'b01, 9'd511});
            if (c == 3) check("wrap_pc_before", 72'(PC2), 72'd511);
            if (c == 4) check("wrap_pc_after", 72'(PC2), 72'd0);
            if (c == 5) check("wrap_halted", {halted2, PC2}, {1'b1, 9'd0});
        end
        check("cmp_no_write", 72'(cmp_wr_bad), 72'd0);
        check("halt_frozen_20", 72'(halt_bad), 72'd0);

        // Reset arriving mid-instruction, in ADD's GET_B cycle.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (16) @(negedge clk);
        @(posedge clk); #1;
        check("pre_rst_get_b", {readnum, loadb, PC}, {3'd1, 1'b1, 9'd3});
        reset = 1'b1;
        #1;
        check("rst_strobes_off", {write, loada, loadb, loadc, loads, bus.mem_cmd}, 72'd0);
        @(posedge clk); #1 reset = 1'b0;
        check("rst_state_pc", {PC, bus.mem_cmd, halted, write}, 72'd0);
        @(posedge clk); #1;
        check("rst_then_if1", {bus.mem_cmd, bus.mem_addr}, {2'b01, 9'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
